// File: rtl/mmio_uart_pkg.sv
// ---------------------------------------------------------------------------
// mmio_uart_pkg
//   Shared definitions for the memory-mapped UART transmitter: default bus
//   addresses, TX FSM state encoding and status register bit positions.
//
//   Optional feature macro: UART_PARITY_EN
//     defined   -> the PARITY state encoding is available (8E1 frames)
//     undefined -> 8N1 only, no PARITY state
// ---------------------------------------------------------------------------
package mmio_uart_pkg;

   // Default register addresses on the 24-bit CPU data bus.
   localparam logic [23:0] DEFAULT_DATA_ADDR = 24'hFFFFFE;
   localparam logic [23:0] DEFAULT_STAT_ADDR = 24'hFFFFFD;

   // TX FSM state encoding. Exposed on the debug port of the top level.
`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd4
   } tx_state_t;
`endif

   // Status register layout.
   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_OVF_BIT   = 2;
   localparam int STAT_BUSY_BIT  = 3;
   localparam int STAT_COUNT_LSB = 8;

   // Even parity bit over one data byte: makes the total number of ones even.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock show-ahead FIFO. rdata always presents the oldest entry, so
//   a pop consumes the value visible in the same cycle.
//
//   Ports
//     clk, rst    clock, synchronous active-high reset (empties the FIFO)
//     en          clock enable; nothing changes while low
//     push, wdata write request and data; ignored when full unless a pop
//                 happens in the same cycle
//     pop, rdata  read request and head-of-queue data; ignored when empty
//     full, empty occupancy flags
//     count       number of stored entries (0..DEPTH)
//
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   // A push into a full FIFO is legal when a pop frees the slot in the
   // same cycle: the write lands in the slot the read pointer just left
   // behind only after it has been read.
   assign pop_ok  = en && pop && !empty;
   assign push_ok = en && push && (!full || pop_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage has no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped console transmitter. CPU byte writes to DATA_ADDR are
//   queued in a FIFO and sent as UART frames on o_txd. Firmware polls the
//   status register at STAT_ADDR to avoid overrunning the FIFO.
//
//   Ports
//     i_clk, i_rst  system clock, synchronous active-high reset
//     i_clk_en      global clock enable; all state holds while low
//     i_daddr       CPU data address
//     i_wdata       CPU write data, only [7:0] is used
//     i_wr, i_rd    CPU write / read strobes
//     o_rdata       registered read data (1-cycle latency, holds between reads)
//     o_txd         UART serial output, idle high, driven from a flop
//     o_busy        FIFO non-empty or frame in progress
//     o_dbg_state   current TX FSM state
//
//   Status register: [0]=full [1]=empty [2]=overflow(sticky, clear on read)
//                    [3]=busy [7:4]=0 [31:8]=FIFO fill count
//
//   Optional feature macro: UART_PARITY_EN adds an even parity bit between
//   the data bits and the stop bit (11-bit frames).
// ---------------------------------------------------------------------------
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter int                ADDR_W       = 24,
   parameter logic [ADDR_W-1:0] DATA_ADDR    = DEFAULT_DATA_ADDR,
   parameter logic [ADDR_W-1:0] STAT_ADDR    = DEFAULT_STAT_ADDR,
   parameter int                FIFO_DEPTH   = 16,
   parameter int                CLKS_PER_BIT = 868
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clk_en,
   input  logic [ADDR_W-1:0] i_daddr,
   input  logic [31:0]       i_wdata,
   input  logic              i_wr,
   input  logic              i_rd,
   output logic [31:0]       o_rdata,
   output logic              o_txd,
   output logic              o_busy,
   output tx_state_t         o_dbg_state
);

   localparam int                CW        = $clog2(CLKS_PER_BIT);
   localparam int                FAW       = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0]     BAUD_LOAD = CW'(CLKS_PER_BIT - 1);

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic data_wr;
   logic stat_rd;

   assign data_wr = i_wr && (i_daddr == DATA_ADDR);
   assign stat_rd = i_rd && (i_daddr == STAT_ADDR);

   // Upper write-data bits carry nothing for this peripheral.
   logic unused_wdata;
   assign unused_wdata = ^i_wdata[31:8];

   // ------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------
   logic [7:0]  fifo_rdata;
   logic        fifo_full;
   logic        fifo_empty;
   logic [FAW:0] fifo_count;
   logic        pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .en    (i_clk_en),
      .push  (data_wr),
      .wdata (i_wdata[7:0]),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A write is dropped only when the FIFO is full and the transmitter is
   // not taking a byte out in the same cycle.
   logic push_drop;
   assign push_drop = data_wr && fifo_full && !pop;

   // ------------------------------------------------------------------
   // TX FSM: state register / next-state logic / output logic
   // ------------------------------------------------------------------
   tx_state_t     state_q, state_n;
   logic [CW-1:0] baud_q,  baud_n;
   logic [2:0]    bit_q,   bit_n;
   logic [7:0]    byte_q,  byte_n;
   logic          txd_q,   txd_n;
   logic          bit_end;

   // The baud counter counts down; the current bit time ends when it hits 0.
   assign bit_end = (baud_q == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         txd_q   <= 1'b1;
      end else if (i_clk_en) begin
         state_q <= state_n;
         baud_q  <= baud_n;
         bit_q   <= bit_n;
         byte_q  <= byte_n;
         txd_q   <= txd_n;
      end
   end

   always_comb begin
      state_n = state_q;
      baud_n  = baud_q;
      bit_n   = bit_q;
      byte_n  = byte_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               byte_n  = fifo_rdata;
               state_n = ST_START;
               baud_n  = BAUD_LOAD;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_n = ST_DATA;
               bit_n   = 3'd0;
               baud_n  = BAUD_LOAD;
            end else begin
               baud_n  = baud_q - 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_n = BAUD_LOAD;
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
               end else begin
                  bit_n = bit_q + 3'd1;
               end
            end else begin
               baud_n = baud_q - 1'b1;
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               state_n = ST_STOP;
               baud_n  = BAUD_LOAD;
            end else begin
               baud_n  = baud_q - 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               // Chain straight into the next start bit when more data is
               // queued, so consecutive frames have no idle gap.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  byte_n  = fifo_rdata;
                  state_n = ST_START;
                  baud_n  = BAUD_LOAD;
               end else begin
                  state_n = ST_IDLE;
                  baud_n  = '0;
               end
            end else begin
               baud_n = baud_q - 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            baud_n  = '0;
         end
      endcase
   end

   // The line level is computed from the *next* state and registered, so
   // o_txd changes on the same edge as the state and comes from a flop.
   always_comb begin
      txd_n = 1'b1;
      case (state_n)
         ST_START:  txd_n = 1'b0;
         ST_DATA:   txd_n = byte_n[bit_n];
`ifdef UART_PARITY_EN
         ST_PARITY: txd_n = even_parity(byte_n);
`endif
         default:   txd_n = 1'b1;
      endcase
   end

   assign o_txd       = txd_q;
   assign o_busy      = !fifo_empty || (state_q != ST_IDLE);
   assign o_dbg_state = state_q;

   // ------------------------------------------------------------------
   // Overflow flag and status / read-data register
   // ------------------------------------------------------------------
   logic        ovf_q;
   logic [31:0] status;
   logic [31:0] rdata_q;

   always_comb begin
      status                                = '0;
      status[STAT_FULL_BIT]                 = fifo_full;
      status[STAT_EMPTY_BIT]                = fifo_empty;
      status[STAT_OVF_BIT]                  = ovf_q;
      status[STAT_BUSY_BIT]                 = o_busy;
      status[STAT_COUNT_LSB +: (FAW + 1)]   = fifo_count;
   end

   // A drop in the same cycle as a status read keeps the flag set, so the
   // loss is reported by the next read rather than silently cleared.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ovf_q <= 1'b0;
      end else if (i_clk_en) begin
         if (push_drop) begin
            ovf_q <= 1'b1;
         end else if (stat_rd) begin
            ovf_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rdata_q <= '0;
      end else if (i_clk_en && i_rd) begin
         rdata_q <= stat_rd ? status : 32'd0;
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=16.
//   The reference model keeps the queued bytes in a queue and the line as a
//   queue of per-clock levels built from whole frames; every cycle the DUT
//   outputs are compared with it, and directed scenarios add spec-level
//   checks on status values and frame length.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mmio_uart_tx;
   import mmio_uart_pkg::*;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 16;
   localparam logic [23:0] DADDR = 24'hFFFFFE;
   localparam logic [23:0] SADDR = 24'hFFFFFD;
`ifdef UART_PARITY_EN
   localparam int          NBITS = 11;
`else
   localparam int          NBITS = 10;
`endif

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic [23:0] daddr = '0;
   logic [31:0] wdata = '0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [31:0] rdata;
   logic        txd;
   logic        busy;
   tx_state_t   dbg_state;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .ADDR_W       (24),
      .DATA_ADDR    (DADDR),
      .STAT_ADDR    (SADDR),
      .FIFO_DEPTH   (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_clk_en    (clk_en),
      .i_daddr     (daddr),
      .i_wdata     (wdata),
      .i_wr        (wr),
      .i_rd        (rd),
      .o_rdata     (rdata),
      .o_txd       (txd),
      .o_busy      (busy),
      .o_dbg_state (dbg_state)
   );

   // ---------------- checker ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  exp_q[$];      // bytes accepted but not yet started
   bit          line_q[$];     // per-clock line levels still to be sent
   bit          m_txd   = 1'b1;
   bit          m_busy  = 1'b0;
   bit          m_ovf   = 1'b0;
   logic [31:0] m_rdata = '0;
   bit          mon_en  = 1'b0;

   task automatic add_frame(input logic [7:0] b);
      bit lv[$];
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(b[i]);
`ifdef UART_PARITY_EN
      lv.push_back(^b);
`endif
      lv.push_back(1'b1);
      foreach (lv[i]) begin
         for (int k = 0; k < CPB; k++) line_q.push_back(lv[i]);
      end
   endtask

   always @(posedge clk) begin : model
      int  pre_size;
      bit  pre_ovf, pre_busy, popped, active, dropped;
      mon_en <= 1'b1;
      if (rst) begin
         exp_q.delete();
         line_q.delete();
         m_txd   = 1'b1;
         m_busy  = 1'b0;
         m_ovf   = 1'b0;
         m_rdata = '0;
      end else if (clk_en) begin
         pre_size = exp_q.size();
         pre_ovf  = m_ovf;
         pre_busy = m_busy;
         popped   = 1'b0;
         dropped  = 1'b0;
         // A new frame starts the clock after the previous one has ended.
         if (line_q.size() == 0 && exp_q.size() > 0) begin
            add_frame(exp_q.pop_front());
            popped = 1'b1;
         end
         if (line_q.size() > 0) begin
            m_txd  = line_q.pop_front();
            active = 1'b1;
         end else begin
            m_txd  = 1'b1;
            active = 1'b0;
         end
         if (wr && daddr == DADDR) begin
            if (pre_size < DEPTH || popped) exp_q.push_back(wdata[7:0]);
            else dropped = 1'b1;
         end
         if (rd) begin
            if (daddr == SADDR)
               m_rdata = (32'(pre_size) << 8) | (32'(pre_busy) << 3) | (32'(pre_ovf) << 2)
                       | (32'(pre_size == 0) << 1) | 32'(pre_size == DEPTH);
            else
               m_rdata = 32'd0;
         end
         if (dropped) m_ovf = 1'b1;
         else if (rd && daddr == SADDR) m_ovf = 1'b0;
         m_busy = (exp_q.size() > 0) || active;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         check("txd", 32'(txd), 32'(m_txd));
         check("busy", 32'(busy), 32'(m_busy));
         check("rdata", rdata, m_rdata);
      end
   end

   // ---------------- driver tasks (called at #1 after a posedge) ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [23:0] a, input logic [7:0] d);
      daddr = a;
      wdata = {24'($urandom), d};
      wr    = 1'b1;
      tick(1);
      wr    = 1'b0;
   endtask

   task automatic bus_read(input logic [23:0] a, output logic [31:0] v);
      daddr = a;
      rd    = 1'b1;
      tick(1);
      rd    = 1'b0;
      v     = rdata;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (busy === 1'b1 && n < max_cycles) begin
         tick(1);
         n++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic frame_len(input logic [7:0] d, input string tag);
      int n;
      bus_write(DADDR, d);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         tick(1);
      end
      check(tag, 32'(n), 32'(NBITS * CPB + 1));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v;
      tick(3);
      rst = 1'b0;
      // reset state
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      bus_read(SADDR, v);
      check("rst_status", v, 32'h0000_0002);

      // single frame 0x55, exact length
      frame_len(8'h55, "frame_len_55");

      // back-to-back pair, no gap, then clean status
      bus_write(DADDR, 8'h41);
      bus_write(DADDR, 8'h42);
      wait_idle(400);
      tick(1);
      bus_read(SADDR, v);
      check("pair_status", v, 32'h0000_0002);

      // fill: 17 accepted (one popped), 2 dropped
      for (int i = 0; i < 17; i++) bus_write(DADDR, 8'($urandom));
      bus_write(DADDR, 8'hEE);
      bus_write(DADDR, 8'hEF);
      bus_read(SADDR, v);
      check("ovf_status", v, 32'h0000_100D);
      bus_read(SADDR, v);
      check("ovf_cleared", 32'(v[2]), 32'd0);
      check("still_full", 32'(v[0]), 32'd1);
      wait_idle(2000);

      // clock enable freeze mid-DATA
      bus_write(DADDR, 8'hA6);
      tick(12);
      clk_en = 1'b0;
      tick(50);
      clk_en = 1'b1;
      wait_idle(400);

      // reset mid-frame with bytes queued
      for (int i = 0; i < 6; i++) bus_write(DADDR, 8'($urandom));
      tick(14);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midrst_txd", 32'(txd), 32'd1);
      bus_read(SADDR, v);
      check("midrst_status", v, 32'h0000_0002);
      tick(100);
      check("midrst_quiet", 32'(busy), 32'd0);

`ifdef UART_PARITY_EN
      frame_len(8'h07, "frame_len_par07");
`endif

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         clk_en = ($urandom_range(0, 9) != 0);
         rst    = ($urandom_range(0, 599) == 0);
         wr     = ($urandom_range(0, 29) == 0);
         rd     = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0, 1:    daddr = wr ? DADDR : SADDR;
            2:       daddr = SADDR;
            default: daddr = 24'($urandom_range(0, 255));
         endcase
         wdata = $urandom;
         tick(1);
      end
      rst = 1'b0;
      wr  = 1'b0;
      rd  = 1'b0;
      clk_en = 1'b1;
      wait_idle(2000);
      bus_read(SADDR, v);
      check("final_empty", 32'(v[1]), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
